// File: rtl/osnt_sume_ts_extract.sv
// Receive-side timestamp reader: watches a 256-bit RX AXI-Stream, pulls the
// 64-bit transmit stamp out of each packet at a programmable byte offset and
// queues {latency, tx_stamp} per packet on a valid/ready result port.
module osnt_sume_ts_extract #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int TIMESTAMP_WIDTH     = 64,
    parameter int RESULT_FIFO_DEPTH   = 4
) (
    input  logic                           axi_aclk,
    input  logic                           axi_reset,
    input  logic                           en,
    input  logic [31:0]                    rx_ts_pos,
    input  logic [TIMESTAMP_WIDTH-1:0]     stamp_counter,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tlast,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [TIMESTAMP_WIDTH-1:0]     result_latency,
    output logic [TIMESTAMP_WIDTH-1:0]     result_tx_stamp,
    output logic [31:0]                    pkt_count,
    output logic [31:0]                    short_count,
    output logic [31:0]                    drop_count
);

    localparam int TW = TIMESTAMP_WIDTH;
    localparam int AW = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam logic [AW:0]  FIFO_FULL = RESULT_FIFO_DEPTH[AW:0];
    localparam logic [26:0]  BEAT_MAX  = 27'h7FF_FFFF;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEEK = 2'd1;
    localparam logic [1:0] ST_HAVE = 2'd2;
    localparam logic [1:0] ST_SKIP = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [31:3]     pos_q;
    logic [TW-1:0]   arrival_q;
    logic [26:0]     beat_q;
    logic [TW-1:0]   cap_q;

    logic            push_q, short_q;
    logic            push_d, short_d;
    logic [TW-1:0]   lat_q, tx_q;

    logic [2*TW-1:0] mem_q [0:RESULT_FIFO_DEPTH-1];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;

    logic            beat_acc_s;
    logic            in_idle_s;
    logic [31:3]     pos_s;
    logic [26:0]     beat_idx_s;
    logic [TW-1:0]   arrival_s;
    logic [TW-1:0]   field_s;
    logic            hit_s;
    logic [TW-1:0]   push_tx_s;
    logic            pop_s;
    logic            wr_ok_s;
    logic            unused_s;

    // Byte offsets are 8-byte aligned; the low offset bits carry no meaning.
    assign unused_s = ^rx_ts_pos[2:0];

    assign beat_acc_s = s_axis_tvalid & s_axis_tready;
    assign in_idle_s  = (state_q == ST_IDLE);

    // At SOP the live inputs are used so a single-beat packet resolves at once.
    assign pos_s      = in_idle_s ? rx_ts_pos[31:3] : pos_q;
    assign beat_idx_s = in_idle_s ? 27'd0 : beat_q;
    assign arrival_s  = in_idle_s ? stamp_counter : arrival_q;
    assign field_s    = s_axis_tdata[{pos_s[4:3], 6'd0} +: TW];
    assign hit_s      = beat_acc_s && (beat_idx_s == pos_s[31:5]) &&
                        ((in_idle_s && en) || (state_q == ST_SEEK));
    assign push_tx_s  = hit_s ? field_s : cap_q;

    // Packet FSM next-state and end-of-packet outcome.
    always_comb begin
        state_d = state_q;
        push_d  = 1'b0;
        short_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat_acc_s) begin
                    if (en) begin
                        if (hit_s) begin
                            if (s_axis_tlast) push_d  = 1'b1;
                            else              state_d = ST_HAVE;
                        end else begin
                            if (s_axis_tlast) short_d = 1'b1;
                            else              state_d = ST_SEEK;
                        end
                    end else begin
                        if (s_axis_tlast) state_d = ST_IDLE;
                        else              state_d = ST_SKIP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEEK: begin
                if (beat_acc_s && s_axis_tlast) begin
                    state_d = ST_IDLE;
                    if (hit_s) push_d  = 1'b1;
                    else       short_d = 1'b1;
                end else if (hit_s) begin
                    state_d = ST_HAVE;
                end else begin
                    state_d = ST_SEEK;
                end
            end
            ST_HAVE: begin
                if (beat_acc_s && s_axis_tlast) begin
                    state_d = ST_IDLE;
                    push_d  = 1'b1;
                end else begin
                    state_d = ST_HAVE;
                end
            end
            ST_SKIP: begin
                if (beat_acc_s && s_axis_tlast) state_d = ST_IDLE;
                else                            state_d = ST_SKIP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Packet tracking: state, SOP-latched offset/arrival, beat index, captured field.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q   <= ST_IDLE;
            pos_q     <= '0;
            arrival_q <= '0;
            beat_q    <= 27'd0;
            cap_q     <= '0;
        end else begin
            state_q <= state_d;
            if (beat_acc_s && in_idle_s) begin
                pos_q     <= rx_ts_pos[31:3];
                arrival_q <= stamp_counter;
                beat_q    <= 27'd1;
            end else if (beat_acc_s && (beat_q != BEAT_MAX)) begin
                beat_q <= beat_q + 27'd1;
            end else begin
                beat_q <= beat_q;
            end
            if (hit_s) cap_q <= field_s;
            else       cap_q <= cap_q;
        end
    end

    // Latency subtraction stage between end-of-packet and the result queue.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            push_q  <= 1'b0;
            short_q <= 1'b0;
            lat_q   <= '0;
            tx_q    <= '0;
        end else begin
            push_q  <= push_d;
            short_q <= short_d;
            lat_q   <= arrival_s - push_tx_s;
            tx_q    <= push_tx_s;
        end
    end

    // A pop in the same cycle frees a slot before the push is judged.
    assign pop_s   = result_valid & result_ready;
    assign wr_ok_s = push_q & ((count_q != FIFO_FULL) | pop_s);

    // Result queue storage, pointers and statistics counters.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            for (int i = 0; i < RESULT_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pkt_count   <= 32'd0;
            short_count <= 32'd0;
            drop_count  <= 32'd0;
        end else begin
            if (wr_ok_s) begin
                mem_q[wr_ptr_q] <= {lat_q, tx_q};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + 1'b1;
            else       rd_ptr_q <= rd_ptr_q;
            case ({wr_ok_s, pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_q && wr_ok_s)  pkt_count  <= pkt_count + 32'd1;
            else if (push_q)        drop_count <= drop_count + 32'd1;
            else                    pkt_count  <= pkt_count;
            if (short_q) short_count <= short_count + 32'd1;
            else         short_count <= short_count;
        end
    end

    assign result_valid    = (count_q != '0);
    assign result_latency  = mem_q[rd_ptr_q][2*TW-1:TW];
    assign result_tx_stamp = mem_q[rd_ptr_q][TW-1:0];

endmodule

// File: tb/tb_osnt_sume_ts_extract.sv
// Self-checking bench for osnt_sume_ts_extract: directed scenarios plus
// randomized packets checked against a packet-level reference model.
module tb_osnt_sume_ts_extract;

    logic         clk = 1'b0;
    logic         axi_reset;
    logic         en;
    logic [31:0]  rx_ts_pos;
    logic [63:0]  stamp_counter;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [255:0] s_axis_tdata;
    logic         s_axis_tlast;
    logic         result_valid;
    logic         result_ready;
    logic [63:0]  result_latency;
    logic [63:0]  result_tx_stamp;
    logic [31:0]  pkt_count;
    logic [31:0]  short_count;
    logic [31:0]  drop_count;

    int checks = 0;
    int errors = 0;
    int exp_pkt = 0;
    int exp_short = 0;
    int exp_drop = 0;
    int chk_idx = 0;
    logic [127:0] exp_q[$];
    logic [127:0] obs_q[$];

    osnt_sume_ts_extract dut (
        .axi_aclk        (clk),
        .axi_reset       (axi_reset),
        .en              (en),
        .rx_ts_pos       (rx_ts_pos),
        .stamp_counter   (stamp_counter),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tlast    (s_axis_tlast),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_latency  (result_latency),
        .result_tx_stamp (result_tx_stamp),
        .pkt_count       (pkt_count),
        .short_count     (short_count),
        .drop_count      (drop_count)
    );

    always #5 clk = ~clk;

    // Record every result handed over on the result port.
    always @(negedge clk) begin
        if (result_valid === 1'b1 && result_ready === 1'b1)
            obs_q.push_back({result_latency, result_tx_stamp});
    end

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            stamp_counter = stamp_counter + 64'd1;
        end
    endtask

    // Drive one packet; report what the model says it should produce.
    task automatic send_pkt(input int nbeats, input bit en_v, input logic [31:0] pos,
                            input logic [63:0] tx, input bit set_arr, input logic [63:0] arr,
                            input bit noisy, output bit has_res, output logic [127:0] res,
                            output bit is_short);
        logic [255:0] d;
        logic [63:0]  arrival;
        int idx;
        int lane;
        idx  = int'(pos >> 5);
        lane = int'(pos[4:3]);
        arrival = 64'd0;
        if (set_arr) stamp_counter = arr;
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
            if (b == idx) d[lane*64 +: 64] = tx;
            if (noisy && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tready = 1'b0;
                s_axis_tdata  = ~d;
                s_axis_tlast  = 1'($urandom_range(0, 1));
                en            = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                stamp_counter = stamp_counter + 64'd1;
            end
            if (b == 0) begin
                en        = en_v;
                rx_ts_pos = pos;
                arrival   = stamp_counter;
            end else if (noisy) begin
                en        = 1'($urandom_range(0, 1));
                rx_ts_pos = $urandom;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tready = 1'b1;
            s_axis_tdata  = d;
            s_axis_tlast  = (b == nbeats - 1);
            @(posedge clk); #1;
            stamp_counter = stamp_counter + 64'd1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        has_res  = en_v && (nbeats > idx);
        is_short = en_v && !(nbeats > idx);
        res      = {arrival - tx, tx};
    endtask

    task automatic send_exp(input int nbeats, input bit en_v, input logic [31:0] pos,
                            input logic [63:0] tx, input bit set_arr, input logic [63:0] arr,
                            input bit noisy);
        bit hr;
        bit sh;
        logic [127:0] r;
        send_pkt(nbeats, en_v, pos, tx, set_arr, arr, noisy, hr, r, sh);
        if (hr) begin
            exp_q.push_back(r);
            exp_pkt++;
        end
        if (sh) exp_short++;
    endtask

    task automatic drain(input string name);
        result_ready = 1'b1;
        idle(12);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d results expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = chk_idx; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_entry%0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
                end
            end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_reset;
        axi_reset = 1'b1;
        idle(3);
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++;
        if (result_latency !== 64'd0 || result_tx_stamp !== 64'd0) begin
            errors++; $display("FAIL reset_data: got %h/%h expected 0/0", result_latency, result_tx_stamp);
        end
        checks++;
        if (pkt_count !== 32'd0 || short_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++; $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", pkt_count, short_count, drop_count);
        end
        axi_reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        logic [255:0] unused;
        result_ready = 1'b0;
        send_exp(3, 1'b1, 32'h28, 64'h1000, 1'b1, 64'h1500, 1'b0);
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_n1: got %b expected 0", result_valid); end
        @(posedge clk); #1;
        stamp_counter = stamp_counter + 64'd1;
        checks++;
        if (result_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_n2: got %b expected 1", result_valid); end
        checks++;
        if (result_latency !== 64'h500) begin errors++; $display("FAIL basic_latency: got %h expected 500", result_latency); end
        checks++;
        if (result_tx_stamp !== 64'h1000) begin errors++; $display("FAIL basic_tx: got %h expected 1000", result_tx_stamp); end
        checks++;
        if (pkt_count !== 32'd1) begin errors++; $display("FAIL basic_pkt: got %0d expected 1", pkt_count); end
        unused = '0;
        drain("basic");
    endtask

    task automatic test_short;
        send_exp(2, 1'b1, 32'h40, 64'hDEAD_BEEF, 1'b0, 64'd0, 1'b0);
        idle(3);
        checks++;
        if (short_count !== 32'(exp_short)) begin errors++; $display("FAIL short_count: got %0d expected %0d", short_count, exp_short); end
        checks++;
        if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL short_pkt: got %0d expected %0d", pkt_count, exp_pkt); end
        drain("short");
    endtask

    task automatic test_wrap;
        result_ready = 1'b0;
        send_exp(1, 1'b1, 32'h10, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 64'h10, 1'b0);
        idle(2);
        checks++;
        if (result_latency !== 64'h20) begin errors++; $display("FAIL wrap_latency: got %h expected 20", result_latency); end
        drain("wrap");
    endtask

    task automatic test_drop;
        bit hr;
        bit sh;
        logic [127:0] r;
        result_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            send_pkt(1, 1'b1, {27'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))},
                     {$urandom, $urandom}, 1'b0, 64'd0, 1'b0, hr, r, sh);
            if (k < 4) begin exp_q.push_back(r); exp_pkt++; end
            else       exp_drop++;
        end
        idle(3);
        checks++;
        if (drop_count !== 32'(exp_drop)) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop_count, exp_drop); end
        checks++;
        if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL drop_pkt: got %0d expected %0d", pkt_count, exp_pkt); end
        idle(3);
        checks++;
        if (result_valid !== 1'b1 || {result_latency, result_tx_stamp} !== exp_q[chk_idx]) begin
            errors++; $display("FAIL drop_hold: got %b %h expected 1 %h", result_valid,
                               {result_latency, result_tx_stamp}, exp_q[chk_idx]);
        end
        drain("drop");
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("FAIL drop_empty: got %b expected 0", result_valid); end
    endtask

    task automatic test_en_pos;
        send_exp(3, 1'b0, 32'h08, {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
        send_exp(3, 1'b1, 32'h50, {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
        drain("en_pos");
        checks++;
        if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL en_pos_pkt: got %0d expected %0d", pkt_count, exp_pkt); end
    endtask

    task automatic test_back_to_back;
        result_ready = 1'b1;
        for (int k = 0; k < 20; k++)
            send_exp(1, 1'b1, {27'd0, 5'($urandom_range(0, 31))}, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
        drain("b2b");
        checks++;
        if (pkt_count !== 32'(exp_pkt) || drop_count !== 32'(exp_drop)) begin
            errors++; $display("FAIL b2b_counts: got %0d/%0d expected %0d/%0d", pkt_count, drop_count, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_random;
        result_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_exp($urandom_range(1, 6), ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)),
                     {$urandom, $urandom}, 1'b0, 64'd0, 1'b1);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        drain("random");
        checks++;
        if (pkt_count !== 32'(exp_pkt) || short_count !== 32'(exp_short) || drop_count !== 32'(exp_drop)) begin
            errors++; $display("FAIL random_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                               pkt_count, short_count, drop_count, exp_pkt, exp_short, exp_drop);
        end
    endtask

    task automatic test_reset_mid;
        bit hr;
        bit sh;
        logic [127:0] r;
        result_ready = 1'b0;
        send_pkt(1, 1'b1, 32'h0, 64'h55, 1'b0, 64'd0, 1'b0, hr, r, sh);
        idle(3);
        en = 1'b1;
        rx_ts_pos = 32'h0;
        for (int b = 0; b < 2; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tready = 1'b1;
            s_axis_tlast  = 1'b0;
            s_axis_tdata  = {8{$urandom}};
            @(posedge clk); #1;
            stamp_counter = stamp_counter + 64'd1;
        end
        axi_reset = 1'b1;
        @(posedge clk); #1;
        stamp_counter = stamp_counter + 64'd1;
        checks++;
        if (result_valid !== 1'b0 || result_latency !== 64'd0 || result_tx_stamp !== 64'd0) begin
            errors++; $display("FAIL rstmid_result: got %b %h %h expected 0 0 0", result_valid, result_latency, result_tx_stamp);
        end
        checks++;
        if (pkt_count !== 32'd0 || short_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_counts: got %0d/%0d/%0d expected 0/0/0", pkt_count, short_count, drop_count);
        end
        @(posedge clk); #1;
        stamp_counter = stamp_counter + 64'd1;
        axi_reset = 1'b0;
        exp_pkt = 0;
        exp_short = 0;
        exp_drop = 0;
        result_ready = 1'b1;
        send_exp(2, 1'b1, 32'h38, {$urandom, $urandom}, 1'b0, 64'd0, 1'b0);
        drain("rstmid");
        checks++;
        if (pkt_count !== 32'd1 || short_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_after: got %0d/%0d expected 1/0", pkt_count, short_count);
        end
    endtask

    initial begin
        axi_reset     = 1'b1;
        en            = 1'b0;
        rx_ts_pos     = 32'd0;
        stamp_counter = 64'd0;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tlast  = 1'b0;
        result_ready  = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_wrap();
        test_drop();
        test_en_pos();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
